banked_mem: RTL and testbench
=============================

BANKED_MEM -- requirements
Module: banked_mem

Interface
REQ-001 The block SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-002 The block SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-003 The block SHALL have port createdump  input  1  simulation hook; no effect on any state or output.
REQ-004 The block SHALL have port addr  input  16  byte address of the request.
REQ-005 The block SHALL have port data_in  input  16  write data.
REQ-006 The block SHALL have port rd  input  1  read request.
REQ-007 The block SHALL have port wr  input  1  write request.
REQ-008 The block SHALL have port data_out  output  16  read data, meaningful only while rd_valid=1.
REQ-009 The block SHALL have port rd_valid  output  1  one-cycle pulse marking returned read data.
REQ-010 The block SHALL have port stall  output  1  request not accepted this cycle; requester holds rd/wr/addr/data_in.
REQ-011 The block SHALL have port busy  output  4  per-bank occupancy, bit b = bank b.
REQ-012 The block SHALL have port err  output  1  illegal request this cycle.

Function
REQ-013 The block SHALL hold storage as 4 banks x 64 words x 16 bits: bank = addr[2:1], index = addr[8:3], addr[15:9] ignored.
REQ-014 A request SHALL be illegal when rd&wr=1 or addr[0]=1 while rd|wr=1; err is combinational and high in that same cycle only.
REQ-015 An illegal request SHALL be ignored: no storage write, no busy change, no rd_valid, stall=0.
REQ-016 stall SHALL be combinational: stall = (rd|wr) & ~err & busy[addr[2:1]].
REQ-017 A request SHALL be accepted in cycle T when rd|wr=1, err=0 and stall=0.
REQ-018 Acceptance SHALL load the target bank's 3-bit occupancy counter to 4; busy[b] = (counter_b != 0); each nonzero counter decrements by 1 per cycle, giving busy[b]=1 exactly in cycles T+1..T+4.
REQ-019 An accepted write SHALL update storage at the clock edge ending cycle T.
REQ-020 An accepted read SHALL return data through a 2-stage pipeline: rd_valid=1 and data_out = stored word in cycle T+2 only.
REQ-021 data_out SHALL be 16'h0000 in every cycle with rd_valid=0.
REQ-022 Requests to different non-busy banks SHALL be accepted back-to-back, one per cycle; returned reads stay in acceptance order.
REQ-023 A read accepted in T of a word written in an earlier accepted cycle SHALL return the written value.
REQ-024 With rd=wr=0 the block SHALL assert neither stall nor err and change only counters and the pipeline.
REQ-025 Bank counters SHALL saturate at 0 (no wrap to 7).

Reset
REQ-026 When rst=0 at a rising edge, all bank counters, both pipeline stages, busy, rd_valid and data_out SHALL be 0 in the following cycle.
REQ-027 Requests presented while rst=0 SHALL NOT be accepted; reads in flight at reset SHALL be discarded (no rd_valid).
REQ-028 Storage contents SHALL NOT be changed by reset.
REQ-029 stall and err SHALL be 0 while rst=0.

Verification
REQ-030 wr addr=0x0010 data_in=0xBEEF at T; rd addr=0x0010 at T+5 -> stall=0 both times, rd_valid=1 and data_out=0xBEEF at T+7.
REQ-031 wr 0x0010 at T, then wr 0x0018 (same bank 0) from T+1 -> stall=1 in T+1..T+4, accepted at T+5, busy=4'b0001 in T+1..T+4.
REQ-032 rd 0x0000,0x0002,0x0004,0x0006 in T..T+3 -> stall=0 throughout, busy=4'b1111 at T+4, rd_valid in T+2..T+5 in that order.
REQ-033 rd addr=0x0011, then rd=wr=1 addr=0x0020 -> err=1, stall=0 each cycle, busy stays 0, no rd_valid.
REQ-034 rd 0x0000 at T, rst=0 at edge ending T+1 -> no rd_valid at T+2, busy=0 from T+2, storage intact on later read.

Source files
------------

// File: rtl/banked_mem.sv
// Four-bank 16-bit word memory with per-bank busy windows and a two-stage read pipeline.
// Requests to a busy bank stall; malformed requests raise err and are dropped.
module banked_mem (
  input  logic        clk,
  input  logic        rst,
  input  logic        createdump,
  input  logic [15:0] addr,
  input  logic [15:0] data_in,
  input  logic        rd,
  input  logic        wr,
  output logic [15:0] data_out,
  output logic        rd_valid,
  output logic        stall,
  output logic [3:0]  busy,
  output logic        err
);

  logic [1:0]  w_bank;
  logic [5:0]  w_idx;
  logic [7:0]  w_waddr;
  logic        w_req;
  logic        w_err;
  logic        w_stall;
  logic        w_accept;
  logic [3:0]  w_busy;
  logic        w_unused;

  logic [2:0]  r_cnt [4];
  logic [15:0] r_mem [256];
  logic        r_s1_valid;
  logic [15:0] r_s1_data;
  logic        r_s2_valid;
  logic [15:0] r_s2_data;

  assign w_bank  = addr[2:1];
  assign w_idx   = addr[8:3];
  assign w_waddr = {w_bank, w_idx};

  // Upper address bits and the dump hook have no function in hardware.
  assign w_unused = ^{createdump, addr[15:9]};

  always_comb begin
    w_busy = 4'b0000;
    for (int b = 0; b < 4; b++) begin
      w_busy[b] = (r_cnt[b] != 3'd0);
    end
  end

  assign w_req    = rd | wr;
  assign w_err    = rst & w_req & ((rd & wr) | addr[0]);
  assign w_stall  = rst & w_req & ~w_err & w_busy[w_bank];
  assign w_accept = rst & w_req & ~w_err & ~w_busy[w_bank];

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int b = 0; b < 4; b++) begin
        r_cnt[b] <= 3'd0;
      end
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (w_accept && (w_bank == 2'(b))) begin
          r_cnt[b] <= 3'd4;
        end else if (r_cnt[b] != 3'd0) begin
          r_cnt[b] <= r_cnt[b] - 3'd1;
        end
      end
    end
  end

  // Storage is deliberately outside reset; w_accept already excludes reset cycles.
  always_ff @(posedge clk) begin
    if (w_accept && wr) begin
      r_mem[w_waddr] <= data_in;
    end
  end

  // Data stages hold zero whenever their valid is low, so data_out needs no gating.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= 16'h0000;
      r_s2_valid <= 1'b0;
      r_s2_data  <= 16'h0000;
    end else begin
      r_s1_valid <= w_accept & rd;
      r_s1_data  <= (w_accept & rd) ? r_mem[w_waddr] : 16'h0000;
      r_s2_valid <= r_s1_valid;
      r_s2_data  <= r_s1_data;
    end
  end

  assign data_out = r_s2_data;
  assign rd_valid = r_s2_valid;
  assign stall    = w_stall;
  assign busy     = w_busy;
  assign err      = w_err;

endmodule

// File: tb/tb_banked_mem.sv
// Bench for banked_mem: directed scenarios plus random traffic, checked against a
// cycle-indexed model (busy windows from acceptance cycle numbers, a queue of due reads).
module tb_banked_mem;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        createdump = 1'b0;
  logic [15:0] addr = 16'h0000;
  logic [15:0] data_in = 16'h0000;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic [15:0] data_out;
  logic        rd_valid;
  logic        stall;
  logic [3:0]  busy;
  logic        err;

  banked_mem dut (
    .clk        (clk),
    .rst        (rst),
    .createdump (createdump),
    .addr       (addr),
    .data_in    (data_in),
    .rd         (rd),
    .wr         (wr),
    .data_out   (data_out),
    .rd_valid   (rd_valid),
    .stall      (stall),
    .busy       (busy),
    .err        (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [15:0] data;
  } rd_t;

  rd_t         rq[$];
  logic [15:0] mm [256];
  int          last_acc [4];
  int          cyc;
  int          n_vec;
  int          n_miss;

  logic        o_err;
  logic        o_stall;
  logic        o_rv;
  logic [3:0]  o_busy;
  logic [15:0] o_do;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s (cycle %0d): observed %h, expected %h", tag, cyc, obs, exp);
    end
  endtask

  // One clock cycle: drive, check all outputs against the model, advance the model.
  task automatic step(input logic s_rst, input logic s_rd, input logic s_wr,
                      input logic [15:0] s_addr, input logic [15:0] s_din);
    logic        e_err;
    logic        e_stall;
    logic        e_rv;
    logic        acc;
    logic [3:0]  e_busy;
    logic [15:0] e_do;
    int          bk;
    int          wi;
    rst        = s_rst;
    rd         = s_rd;
    wr         = s_wr;
    addr       = s_addr;
    data_in    = s_din;
    createdump = 1'($urandom_range(0, 1));
    #3;
    bk = int'(s_addr[2:1]);
    wi = bk * 64 + int'(s_addr[8:3]);
    for (int b = 0; b < 4; b++) begin
      e_busy[b] = (cyc > last_acc[b]) && (cyc <= last_acc[b] + 4);
    end
    e_err   = s_rst && (s_rd || s_wr) && ((s_rd && s_wr) || s_addr[0]);
    e_stall = s_rst && (s_rd || s_wr) && !e_err && e_busy[bk];
    acc     = s_rst && (s_rd || s_wr) && !e_err && !e_busy[bk];
    e_rv    = (rq.size() > 0) && (rq[0].due == cyc);
    e_do    = e_rv ? rq[0].data : 16'h0000;
    o_err   = err;
    o_stall = stall;
    o_rv    = rd_valid;
    o_busy  = busy;
    o_do    = data_out;
    chk("err", 16'(o_err), 16'(e_err));
    chk("stall", 16'(o_stall), 16'(e_stall));
    chk("busy", 16'(o_busy), 16'(e_busy));
    chk("rd_valid", 16'(o_rv), 16'(e_rv));
    chk("data_out", o_do, e_do);
    if (e_rv) void'(rq.pop_front());
    if (!s_rst) begin
      rq.delete();
      for (int b = 0; b < 4; b++) last_acc[b] = -100;
    end else if (acc) begin
      last_acc[bk] = cyc;
      if (s_wr) mm[wi] = s_din;
      else rq.push_back('{due: cyc + 2, data: mm[wi]});
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
  endtask

  initial begin
    logic [15:0] keep;
    int          r;
    logic [15:0] ra;
    n_vec  = 0;
    n_miss = 0;
    cyc    = 0;
    for (int b = 0; b < 4; b++) last_acc[b] = -100;
    repeat (2) @(posedge clk);
    #1;

    // Requests during reset: never accepted, no err/stall.
    step(1'b0, 1'b1, 1'b1, 16'h0001, 16'h1234);
    chk("rst_err", 16'(o_err), 16'h0);
    step(1'b0, 1'b0, 1'b1, 16'h0010, 16'h5555);
    chk("rst_busy", 16'(o_busy), 16'h0);
    idle(1);
    chk("reset_rv", 16'(o_rv), 16'h0);
    chk("reset_do", o_do, 16'h0);

    // Prefill all words; a bank reappears only after its busy window closes.
    for (int i = 0; i < 256; i++) begin
      step(1'b1, 1'b0, 1'b1, 16'(i * 2), 16'($urandom));
      if ((i % 4) == 3) idle(1);
    end
    idle(6);

    // Write then read of the same word.
    step(1'b1, 1'b0, 1'b1, 16'h0010, 16'hBEEF);
    chk("wr_stall", 16'(o_stall), 16'h0);
    idle(4);
    step(1'b1, 1'b1, 1'b0, 16'h0010, 16'h0000);
    chk("rd_stall", 16'(o_stall), 16'h0);
    idle(1);
    idle(1);
    chk("rd_beef_valid", 16'(o_rv), 16'h1);
    chk("rd_beef_data", o_do, 16'hBEEF);
    idle(6);

    // Same-bank conflict: second write held until the window ends.
    step(1'b1, 1'b0, 1'b1, 16'h0010, 16'h1111);
    for (int k = 1; k <= 4; k++) begin
      step(1'b1, 1'b0, 1'b1, 16'h0018, 16'h2222);
      chk("conflict_stall", 16'(o_stall), 16'h1);
      chk("conflict_busy", 16'(o_busy), 16'h0001);
    end
    step(1'b1, 1'b0, 1'b1, 16'h0018, 16'h2222);
    chk("conflict_accept", 16'(o_stall), 16'h0);
    idle(6);

    // Back-to-back reads across all four banks.
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1'b1, 1'b0, 16'(k * 2), 16'h0000);
      chk("b2b_stall", 16'(o_stall), 16'h0);
    end
    idle(1);
    chk("b2b_busy", 16'(o_busy), 16'h000F);
    idle(6);

    // Illegal requests.
    step(1'b1, 1'b1, 1'b0, 16'h0011, 16'h0000);
    chk("odd_err", 16'(o_err), 16'h1);
    chk("odd_stall", 16'(o_stall), 16'h0);
    step(1'b1, 1'b1, 1'b1, 16'h0020, 16'hAAAA);
    chk("rdwr_err", 16'(o_err), 16'h1);
    idle(3);
    chk("illegal_busy", 16'(o_busy), 16'h0);
    idle(3);

    // Reset discards an in-flight read; storage survives.
    keep = mm[0];
    step(1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000);
    step(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    idle(1);
    chk("flush_rv", 16'(o_rv), 16'h0);
    chk("flush_busy", 16'(o_busy), 16'h0);
    step(1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000);
    idle(2);
    chk("keep_rv", 16'(o_rv), 16'h1);
    chk("keep_data", o_do, keep);
    idle(6);

    // Random traffic with occasional resets and malformed requests.
    for (int n = 0; n < 3000; n++) begin
      r  = int'($urandom_range(0, 9));
      ra = 16'($urandom);
      if ($urandom_range(0, 7) != 0) ra[0] = 1'b0;
      step(1'($urandom_range(0, 99) != 0), 1'(r <= 3 || r == 7),
           1'((r >= 4 && r <= 7)), ra, 16'($urandom));
    end
    idle(6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
